// File: rtl/gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gpio_irq_ctrl
// Description : Parametrised GPIO controller. Per bit: synchronises and
//               optionally debounces switch inputs, mirrors a CSR-driven LED
//               value, and collects level or rising-edge events into sticky
//               pending flags that raise one maskable interrupt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_WIDTH      - number of GPIO bits (>= 1)
//   SYNC_STAGES     - input synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES - cycles a new input value must hold before acceptance
//                     (>= 1); ignored when debouncing is compiled out
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sw          in   raw asynchronous switch pins
//   led         out  registered LED drive (led_reg delayed one cycle)
//   sw_reg      out  debounced switch state
//   led_reg     in   LED value from the CSR bank
//   irq_mask    in   1 = bit may assert irq
//   irq_edge    in   0 = level-high source, 1 = rising-edge source
//   irq_clr     in   write-1-to-clear strobe for irq_pending
//   irq_pending out  sticky per-bit event flags
//   irq         out  registered OR of irq_pending & irq_mask
// Build option:
//   GPIO_DEBOUNCE_EN - when defined, per-bit debounce counters are built;
//                      otherwise sw_reg follows the synchroniser every cycle.
// ============================================================================
module gpio_irq_ctrl #(
    parameter int DATA_WIDTH      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] sw,
    output logic [DATA_WIDTH-1:0] led,
    output logic [DATA_WIDTH-1:0] sw_reg,
    input  logic [DATA_WIDTH-1:0] led_reg,
    input  logic [DATA_WIDTH-1:0] irq_mask,
    input  logic [DATA_WIDTH-1:0] irq_edge,
    input  logic [DATA_WIDTH-1:0] irq_clr,
    output logic [DATA_WIDTH-1:0] irq_pending,
    output logic                  irq
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("gpio_irq_ctrl: DATA_WIDTH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("gpio_irq_ctrl: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("gpio_irq_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] w_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce (or straight register when compiled out)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_sw_reg;

`ifdef GPIO_DEBOUNCE_EN
    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_debounce
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_bit;

        // Any return to the accepted value restarts the count, so only an
        // uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (w_sync[g] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_bit <= w_sync[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign r_sw_reg[g] = r_bit;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_reg <= '0;
        end else begin
            r_sw_reg <= w_sync;
        end
    end
`endif

    assign sw_reg = r_sw_reg;

    // ------------------------------------------------------------------
    // LED mirror, event detection, pending flags and interrupt
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_sw_reg_q;
    logic [DATA_WIDTH-1:0] r_led;
    logic [DATA_WIDTH-1:0] r_pending;
    logic                  r_irq;
    logic [DATA_WIDTH-1:0] w_event;

    // Level bits pass sw_reg through; edge bits additionally require the
    // previous sample to have been low.
    assign w_event = r_sw_reg & ~(irq_edge & r_sw_reg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_reg_q <= '0;
            r_led      <= '0;
            r_pending  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_sw_reg_q <= r_sw_reg;
            r_led      <= led_reg;
            // A new event wins over a simultaneous clear.
            r_pending  <= w_event | (r_pending & ~irq_clr);
            r_irq      <= |(r_pending & irq_mask);
        end
    end

    assign led         = r_led;
    assign irq_pending = r_pending;
    assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_irq_ctrl
// Description : Directed self-checking bench for gpio_irq_ctrl (default
//               parameters). Latencies follow the GPIO_DEBOUNCE_EN setting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_irq_ctrl;

    localparam int c_w   = 4;
    localparam int c_s   = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int c_lat = 16;
`else
    localparam int c_lat = 1;
`endif
    // Edge (after sw change) at which sw_reg updates
    localparam int c_sw_edge = c_s + c_lat;

    logic           clk;
    logic           rst_n;
    logic [c_w-1:0] sw;
    logic [c_w-1:0] led;
    logic [c_w-1:0] sw_reg;
    logic [c_w-1:0] led_reg;
    logic [c_w-1:0] irq_mask;
    logic [c_w-1:0] irq_edge;
    logic [c_w-1:0] irq_clr;
    logic [c_w-1:0] irq_pending;
    logic           irq;

    int n_checks = 0;
    int n_errors = 0;

    gpio_irq_ctrl #(
        .DATA_WIDTH      (c_w),
        .SYNC_STAGES     (c_s),
        .DEBOUNCE_CYCLES (16)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .led         (led),
        .sw_reg      (sw_reg),
        .led_reg     (led_reg),
        .irq_mask    (irq_mask),
        .irq_edge    (irq_edge),
        .irq_clr     (irq_clr),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Reset ----------------
        rst_n    = 1'b0;
        sw       = 4'hF;
        led_reg  = 4'hA;
        irq_mask = 4'h0;
        irq_edge = 4'h0;
        irq_clr  = 4'h0;
        tick(3);
        check("rst_led",     32'(led),         32'h0);
        check("rst_sw_reg",  32'(sw_reg),      32'h0);
        check("rst_pending", 32'(irq_pending), 32'h0);
        check("rst_irq",     32'(irq),         32'h0);
        sw    = 4'h0;
        rst_n = 1'b1;
        tick(1);
        check("led_after_rst", 32'(led), 32'hA);
        led_reg = 4'h5;
        tick(1);
        check("led_follow", 32'(led), 32'h5);
        tick(5);
        check("idle_pending", 32'(irq_pending), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
        // ---------------- Glitch rejection ----------------
        sw = 4'b0001;
        tick(10);
        sw = 4'b0000;
        tick(30);
        check("glitch_sw_reg",  32'(sw_reg),      32'h0);
        check("glitch_pending", 32'(irq_pending), 32'h0);
`endif

        // ---------------- Accept, level bit 0 ----------------
        irq_mask = 4'b0001;
        sw       = 4'b0001;
        for (int k = 1; k <= c_sw_edge + 3; k++) begin
            tick(1);
            check($sformatf("acc_sw_e%0d", k),  32'(sw_reg[0]),      32'(k >= c_sw_edge));
            check($sformatf("acc_pnd_e%0d", k), 32'(irq_pending[0]), 32'(k >= c_sw_edge + 1));
            check($sformatf("acc_irq_e%0d", k), 32'(irq),            32'(k >= c_sw_edge + 2));
        end
        sw = 4'b0000;
        tick(c_sw_edge + 2);
        check("b0_sticky", 32'(irq_pending), 32'h1);
        irq_clr = 4'b0001;
        tick(1);
        irq_clr = 4'b0000;
        check("b0_clr_pnd",    32'(irq_pending), 32'h0);
        check("b0_clr_irq_hi", 32'(irq),         32'h1);
        tick(1);
        check("b0_clr_irq_lo", 32'(irq),         32'h0);

        // ---------------- Edge mode, bit 1 ----------------
        irq_mask = 4'b0010;
        irq_edge = 4'b0010;
        sw       = 4'b0010;
        tick(c_sw_edge + 2);
        check("edge_pnd", 32'(irq_pending), 32'h2);
        check("edge_irq", 32'(irq),         32'h1);
        irq_clr = 4'b0010;
        tick(1);
        irq_clr = 4'b0000;
        check("edge_clr_pnd",    32'(irq_pending), 32'h0);
        check("edge_clr_irq_hi", 32'(irq),         32'h1);
        tick(1);
        check("edge_clr_irq_lo", 32'(irq),         32'h0);
        check("edge_stay_clr",   32'(irq_pending), 32'h0);

        // Switch to level mode with input still high: pending re-sets.
        irq_edge = 4'b0000;
        tick(1);
        check("lvl_reset_pnd", 32'(irq_pending), 32'h2);
        tick(1);
        check("lvl_irq", 32'(irq), 32'h1);
        irq_clr = 4'b0010;
        tick(1);
        irq_clr = 4'b0000;
        check("lvl_clr_noeffect", 32'(irq_pending), 32'h2);

        // Clean up bit 1
        sw       = 4'b0000;
        irq_mask = 4'b0000;
        tick(c_sw_edge + 1);
        irq_clr = 4'hF;
        tick(1);
        irq_clr = 4'h0;
        check("cleanup_pnd", 32'(irq_pending), 32'h0);
        tick(1);
        check("cleanup_irq", 32'(irq), 32'h0);

        // ---------------- Set/clear collision, bit 2 edge ----------------
        irq_edge = 4'b0100;
        sw       = 4'b0100;
        tick(c_sw_edge);
        check("col_sw_reg",  32'(sw_reg),      32'h4);
        check("col_pre_pnd", 32'(irq_pending), 32'h0);
        irq_clr = 4'b0100;
        tick(1);
        irq_clr = 4'b0000;
        check("col_set_wins", 32'(irq_pending), 32'h4);

        // ---------------- Mask ----------------
        tick(1);
        check("mask_off_irq", 32'(irq), 32'h0);
        check("mask_off_pnd", 32'(irq_pending), 32'h4);
        irq_mask = 4'b0100;
        check("mask_no_edge_yet", 32'(irq), 32'h0);
        tick(1);
        check("mask_on_irq", 32'(irq), 32'h1);

        // ---------------- Reset mid-debounce ----------------
        sw = 4'b1100;
        tick(c_s + 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sw_reg",  32'(sw_reg),      32'h0);
        check("mid_rst_pending", 32'(irq_pending), 32'h0);
        check("mid_rst_irq",     32'(irq),         32'h0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= c_sw_edge + 1; k++) begin
            tick(1);
            check($sformatf("rel_sw_e%0d", k), 32'(sw_reg), (k >= c_sw_edge) ? 32'hC : 32'h0);
        end
        check("rel_pnd", 32'(irq_pending), 32'hC);
        tick(1);
        check("rel_irq", 32'(irq), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
